// File: rtl/sd_clk_pkg.sv
// Shared types, DRP register map and divider encoding helpers for the
// SD clock MMCM reconfiguration controller.
package sd_clk_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RST_ON,
        ST_RD1,
        ST_WR1,
        ST_VF1,
        ST_RD2,
        ST_WR2,
        ST_VF2,
        ST_RST_OFF,
        ST_WAIT_LOCK,
        ST_FIN
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_DRDY_TO = 2'd2,
        ERR_LOCK_TO = 2'd3
    } err_t;

    localparam logic [6:0]  ADDR_REG08  = 7'h08;
    localparam logic [6:0]  ADDR_REG09  = 7'h09;
    localparam logic [15:0] KEEP_MASK08 = 16'h1000;
    localparam logic [15:0] KEEP_MASK09 = 16'hFC00;
    localparam logic [7:0]  DIV_MAX     = 8'd126;

    function automatic logic div_illegal(input logic [7:0] div);
        return (div == 8'd0) || (div > DIV_MAX);
    endfunction

    // CLKOUT0 reg1: high time in [11:6], low time in [5:0], phase mux forced to 0.
    function automatic logic [15:0] reg08_val(input logic [15:0] rd, input logic [7:0] div);
        logic [5:0] high;
        logic [5:0] low;
        high = 6'(div >> 1);
        low  = 6'(div - (div >> 1));
        return (rd & KEEP_MASK08) | {4'b0000, high, low};
    endfunction

    // CLKOUT0 reg2: edge in bit 7, no-count in bit 6, delay time forced to 0.
    function automatic logic [15:0] reg09_val(input logic [15:0] rd, input logic [7:0] div);
        logic edge_b;
        logic nocount;
        edge_b  = div[0];
        nocount = (div == 8'd1);
        return (rd & KEEP_MASK09) | {8'h00, edge_b, nocount, 6'b000000};
    endfunction

    function automatic logic holds_mmcm_rst(input state_t s);
        return s inside {ST_RST_ON, ST_RD1, ST_WR1, ST_VF1, ST_RD2, ST_WR2, ST_VF2};
    endfunction

endpackage

// File: rtl/sd_clk_drp_access.sv
// Single DRP transaction: one-cycle den, address/data held until drdy,
// and a timeout if drdy does not arrive within DRDY_TIMEOUT cycles.
module sd_clk_drp_access #(
    parameter int DRDY_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        we,
    input  logic [6:0]  addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        timeout,
    output logic [6:0]  daddr,
    output logic        den,
    output logic        dwe,
    output logic [15:0] din,
    input  logic [15:0] dout,
    input  logic        drdy
);

    localparam int CW = $clog2(DRDY_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DRDY_TIMEOUT - 1);

    logic          pend_q, pend_d;
    logic          den_q, den_d;
    logic          dwe_q, dwe_d;
    logic [6:0]    daddr_q, daddr_d;
    logic [15:0]   din_q, din_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // drdy only counts while a transaction is pending; stray strobes fall through.
    always_comb begin
        pend_d  = pend_q;
        den_d   = 1'b0;
        dwe_d   = 1'b0;
        daddr_d = daddr_q;
        din_d   = din_q;
        cnt_d   = cnt_q;
        ack     = pend_q && drdy;
        timeout = pend_q && !drdy && (cnt_q == CNT_LAST);
        if (pend_q) begin
            cnt_d = cnt_q + CW'(1);
            if (ack || timeout) begin
                pend_d = 1'b0;
                cnt_d  = '0;
            end
        end else if (start) begin
            pend_d  = 1'b1;
            den_d   = 1'b1;
            dwe_d   = we;
            daddr_d = addr;
            din_d   = wdata;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q  <= 1'b0;
            den_q   <= 1'b0;
            dwe_q   <= 1'b0;
            daddr_q <= '0;
            din_q   <= '0;
            cnt_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            den_q   <= den_d;
            dwe_q   <= dwe_d;
            daddr_q <= daddr_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rdata = dout;
    assign den   = den_q;
    assign dwe   = dwe_q;
    assign daddr = daddr_q;
    assign din   = din_q;

endmodule

// File: rtl/sd_clk_drp_ctrl.sv
// MMCM CLKOUT0 divider reprogramming over DRP with reset/lock sequencing.
// Define SD_CLK_DRP_READBACK_EN to re-read and verify each written register.
module sd_clk_drp_ctrl
    import sd_clk_pkg::*;
#(
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_div,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [7:0]  cur_div,
    output logic [6:0]  sd_clk_daddr,
    output logic        sd_clk_den,
    output logic        sd_clk_dwe,
    output logic [15:0] sd_clk_din,
    input  logic [15:0] sd_clk_dout,
    input  logic        sd_clk_drdy,
    output logic        clk_wiz1_rst,
    input  logic        sd_clk_locked
);

    localparam int LW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_TIMEOUT - 1);
    localparam logic [LW-1:0] LOCK_BLANK = LW'(2);

    state_t        state_q, state_d;
    err_t          err_q, err_d;
    logic [7:0]    cur_div_q, cur_div_d;
    logic [7:0]    div_q, div_d;
    logic [15:0]   rd_val_q, rd_val_d;
    logic          issued_q, issued_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic          clk_wiz1_rst_q, clk_wiz1_rst_d;
`ifdef SD_CLK_DRP_READBACK_EN
    logic [15:0]   wr_val_q, wr_val_d;
    logic          acc_verify;
`endif

    logic          acc_state;
    logic          acc_start;
    logic          acc_we;
    logic [6:0]    acc_addr;
    logic [15:0]   acc_wdata;
    logic          acc_ack;
    logic          acc_timeout;
    logic [15:0]   acc_rdata;
    state_t        ack_next;

    sd_clk_drp_access #(
        .DRDY_TIMEOUT(DRDY_TIMEOUT)
    ) u_access (
        .clk     (clk),
        .rstn    (rstn),
        .start   (acc_start),
        .we      (acc_we),
        .addr    (acc_addr),
        .wdata   (acc_wdata),
        .ack     (acc_ack),
        .rdata   (acc_rdata),
        .timeout (acc_timeout),
        .daddr   (sd_clk_daddr),
        .den     (sd_clk_den),
        .dwe     (sd_clk_dwe),
        .din     (sd_clk_din),
        .dout    (sd_clk_dout),
        .drdy    (sd_clk_drdy)
    );

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        cur_div_d  = cur_div_q;
        div_d      = div_q;
        rd_val_d   = rd_val_q;
        issued_d   = issued_q;
        lock_cnt_d = lock_cnt_q;
`ifdef SD_CLK_DRP_READBACK_EN
        wr_val_d   = wr_val_q;
        acc_verify = 1'b0;
`endif
        acc_state  = 1'b0;
        acc_start  = 1'b0;
        acc_we     = 1'b0;
        acc_addr   = ADDR_REG08;
        acc_wdata  = 16'h0000;
        ack_next   = ST_IDLE;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    div_d = req_div;
                    if (div_illegal(req_div)) begin
                        err_d   = ERR_ILLEGAL;
                        state_d = ST_FIN;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = ST_RST_ON;
                    end
                end
            end
            ST_RST_ON: state_d = ST_RD1;
            ST_RD1: begin
                acc_state = 1'b1;
                ack_next  = ST_WR1;
            end
            ST_WR1: begin
                acc_state = 1'b1;
                acc_we    = 1'b1;
                acc_wdata = reg08_val(rd_val_q, div_q);
`ifdef SD_CLK_DRP_READBACK_EN
                ack_next  = ST_VF1;
`else
                ack_next  = ST_RD2;
`endif
            end
`ifdef SD_CLK_DRP_READBACK_EN
            ST_VF1: begin
                acc_state  = 1'b1;
                acc_verify = 1'b1;
                ack_next   = ST_RD2;
            end
`endif
            ST_RD2: begin
                acc_state = 1'b1;
                acc_addr  = ADDR_REG09;
                ack_next  = ST_WR2;
            end
            ST_WR2: begin
                acc_state = 1'b1;
                acc_we    = 1'b1;
                acc_addr  = ADDR_REG09;
                acc_wdata = reg09_val(rd_val_q, div_q);
`ifdef SD_CLK_DRP_READBACK_EN
                ack_next  = ST_VF2;
`else
                ack_next  = ST_RST_OFF;
`endif
            end
`ifdef SD_CLK_DRP_READBACK_EN
            ST_VF2: begin
                acc_state  = 1'b1;
                acc_verify = 1'b1;
                acc_addr   = ADDR_REG09;
                ack_next   = ST_RST_OFF;
            end
`endif
            ST_RST_OFF: begin
                lock_cnt_d = '0;
                state_d    = ST_WAIT_LOCK;
            end
            // locked may still reflect the old configuration right after reset release
            ST_WAIT_LOCK: begin
                lock_cnt_d = lock_cnt_q + LW'(1);
                if ((lock_cnt_q >= LOCK_BLANK) && sd_clk_locked) begin
                    cur_div_d = div_q;
                    state_d   = ST_FIN;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    err_d   = ERR_LOCK_TO;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (acc_state) begin
            if (!issued_q) begin
                acc_start = 1'b1;
                issued_d  = 1'b1;
            end else if (acc_timeout) begin
                issued_d = 1'b0;
                err_d    = ERR_DRDY_TO;
                state_d  = ST_FIN;
            end else if (acc_ack) begin
                issued_d = 1'b0;
                state_d  = ack_next;
                if (!acc_we) begin
                    rd_val_d = acc_rdata;
                end
`ifdef SD_CLK_DRP_READBACK_EN
                if (acc_we) begin
                    wr_val_d = acc_wdata;
                end
                if (acc_verify && (acc_rdata != wr_val_q)) begin
                    err_d   = ERR_LOCK_TO;
                    state_d = ST_FIN;
                end
`endif
            end
        end

        clk_wiz1_rst_d = holds_mmcm_rst(state_d);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_IDLE;
            err_q          <= ERR_OK;
            cur_div_q      <= '0;
            div_q          <= '0;
            rd_val_q       <= '0;
            issued_q       <= 1'b0;
            lock_cnt_q     <= '0;
            clk_wiz1_rst_q <= 1'b0;
`ifdef SD_CLK_DRP_READBACK_EN
            wr_val_q       <= '0;
`endif
        end else begin
            state_q        <= state_d;
            err_q          <= err_d;
            cur_div_q      <= cur_div_d;
            div_q          <= div_d;
            rd_val_q       <= rd_val_d;
            issued_q       <= issued_d;
            lock_cnt_q     <= lock_cnt_d;
            clk_wiz1_rst_q <= clk_wiz1_rst_d;
`ifdef SD_CLK_DRP_READBACK_EN
            wr_val_q       <= wr_val_d;
`endif
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_FIN);
    assign err_code     = err_q;
    assign cur_div      = cur_div_q;
    assign clk_wiz1_rst = clk_wiz1_rst_q;

endmodule
